// File: rtl/alu_frame_parser.sv
// Byte-stream front end for the UART ALU: parses the command header and reassembles
// little-endian operands into first/last-framed beats, flagging malformed or stalled frames.
module alu_frame_parser #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MaxOperands   = 16,
  parameter int unsigned TimeoutCycles = 5600
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           s_tdata_i,
  input  logic                 s_tvalid_i,
  output logic                 s_tready_o,
  output logic [DataWidth-1:0] m_operand_o,
  output logic [1:0]           m_opcode_o,
  output logic                 m_first_o,
  output logic                 m_last_o,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [2:0]           err_code_o
);

  localparam int unsigned B     = DataWidth / 8;
  localparam int unsigned ByteW = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned IdxW  = $clog2(MaxOperands);
  localparam int unsigned CntW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  localparam logic [ByteW-1:0] LastByte   = ByteW'(B - 1);
  localparam logic [CntW:0]    TimeoutVal = (CntW + 1)'(TimeoutCycles);

  localparam logic [2:0] ErrOpcode   = 3'd1;
  localparam logic [2:0] ErrReserved = 3'd2;
  localparam logic [2:0] ErrLength   = 3'd3;
  localparam logic [2:0] ErrDivCount = 3'd4;
  localparam logic [2:0] ErrTimeout  = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StHdr1,
    StHdr2,
    StHdr3,
    StData,
    StOut,
    StDrop
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           op_byte_q, op_byte_d;
  logic                 rsv_bad_q, rsv_bad_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [ByteW-1:0]     byte_q, byte_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [IdxW-1:0]      last_idx_q, last_idx_d;
  logic [DataWidth-1:0] operand_q, operand_d;
  logic [1:0]           opcode_q, opcode_d;
  logic                 err_q, err_d;
  logic [2:0]           err_code_q, err_code_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic        accept;
  logic        counting;
  logic        timeout;
  logic [CntW:0] cnt_inc;

  logic [31:0] len_w;
  logic [31:0] pay_w;
  logic [31:0] nops_w;
  logic        op_known;
  logic [1:0]  op_enc;
  logic        len_ok;
  logic [2:0]  hdr_err;

  assign s_tready_o  = (state_q != StOut);
  assign m_tvalid_o  = (state_q == StOut);
  assign m_first_o   = (state_q == StOut) && (idx_q == '0);
  assign m_last_o    = (state_q == StOut) && (idx_q == last_idx_q);
  assign busy_o      = (state_q != StIdle);
  assign m_operand_o = operand_q;
  assign m_opcode_o  = opcode_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

  assign accept = s_tvalid_i & s_tready_o;

  // Header validation, evaluated against the length high byte currently on the bus.
  always_comb begin
    len_w    = {16'd0, s_tdata_i, len_lo_q};
    pay_w    = len_w - 32'd4;
    nops_w   = pay_w / B;
    op_known = 1'b1;
    op_enc   = 2'd0;
    case (op_byte_q)
      8'hAD:   op_enc = 2'd0;
      8'h63:   op_enc = 2'd1;
      8'h5B:   op_enc = 2'd2;
      default: op_known = 1'b0;
    endcase
    len_ok = (len_w >= 32'd4) && ((pay_w % B) == 32'd0) &&
             (nops_w >= 32'd2) && (nops_w <= MaxOperands);
    hdr_err = 3'd0;
    if (!op_known) begin
      hdr_err = ErrOpcode;
    end else if (rsv_bad_q) begin
      hdr_err = ErrReserved;
    end else if (!len_ok) begin
      hdr_err = ErrLength;
    end else if ((op_enc == 2'd2) && (nops_w != 32'd2)) begin
      hdr_err = ErrDivCount;
    end
  end

  // Gap timer: only runs while waiting on the line; OUT stalls are downstream's fault.
  always_comb begin
    counting = (state_q == StHdr1) || (state_q == StHdr2) || (state_q == StHdr3) ||
               (state_q == StData) || (state_q == StDrop);
    cnt_inc  = {1'b0, cnt_q} + 1'b1;
    cnt_d    = '0;
    if (counting && !accept) begin
      cnt_d = cnt_inc[CntW-1:0];
    end
    timeout = counting && !accept && (TimeoutCycles != 0) && (cnt_inc == TimeoutVal);
  end

  always_comb begin
    state_d    = state_q;
    op_byte_d  = op_byte_q;
    rsv_bad_d  = rsv_bad_q;
    len_lo_d   = len_lo_q;
    byte_d     = byte_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    operand_d  = operand_q;
    opcode_d   = opcode_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_byte_d = s_tdata_i;
          state_d   = StHdr1;
        end
      end
      StHdr1: begin
        if (accept) begin
          rsv_bad_d = (s_tdata_i != 8'd0);
          state_d   = StHdr2;
        end
      end
      StHdr2: begin
        if (accept) begin
          len_lo_d = s_tdata_i;
          state_d  = StHdr3;
        end
      end
      StHdr3: begin
        if (accept) begin
          if (hdr_err != 3'd0) begin
            err_d      = 1'b1;
            err_code_d = hdr_err;
            state_d    = StDrop;
          end else begin
            idx_d      = '0;
            byte_d     = '0;
            last_idx_d = IdxW'(nops_w - 32'd1);
            opcode_d   = op_enc;
            state_d    = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          if (byte_q == '0) begin
            operand_d = '0;
          end
          operand_d[8*byte_q +: 8] = s_tdata_i;
          if (byte_q == LastByte) begin
            byte_d  = '0;
            state_d = StOut;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      StOut: begin
        if (m_tready_i) begin
          if (idx_q == last_idx_q) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StData;
          end
        end
      end
      StDrop: begin
        if (TimeoutCycles == 0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timeout never coincides with an accepted byte, so it cleanly overrides the case above.
    if (timeout) begin
      state_d = StIdle;
      if (state_q != StDrop) begin
        err_d      = 1'b1;
        err_code_d = ErrTimeout;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_byte_q  <= 8'd0;
      rsv_bad_q  <= 1'b0;
      len_lo_q   <= 8'd0;
      byte_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      operand_q  <= '0;
      opcode_q   <= 2'd0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_byte_q  <= op_byte_d;
      rsv_bad_q  <= rsv_bad_d;
      len_lo_q   <= len_lo_d;
      byte_q     <= byte_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      operand_q  <= operand_d;
      opcode_q   <= opcode_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_frame_parser.sv
// Self-checking bench for alu_frame_parser: table of frames with a beat/error scoreboard,
// plus hand sequences for stall, drop recovery, timeout, 16-bit operands and async reset.
module tb_alu_frame_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_operand;
  logic [1:0]  m_opcode;
  logic        m_first;
  logic        m_last;
  logic        m_tvalid;
  logic        m_tready;
  logic        busy;
  logic        err;
  logic [2:0]  err_code;

  alu_frame_parser #(
    .DataWidth    (32),
    .MaxOperands  (6),
    .TimeoutCycles(100)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .s_tdata_i  (s_tdata),
    .s_tvalid_i (s_tvalid),
    .s_tready_o (s_tready),
    .m_operand_o(m_operand),
    .m_opcode_o (m_opcode),
    .m_first_o  (m_first),
    .m_last_o   (m_last),
    .m_tvalid_o (m_tvalid),
    .m_tready_i (m_tready),
    .busy_o     (busy),
    .err_o      (err),
    .err_code_o (err_code)
  );

  // 16-bit instance
  logic        rst16_n;
  logic [7:0]  s16_tdata;
  logic        s16_tvalid;
  logic        s16_tready;
  logic [15:0] m16_operand;
  logic [1:0]  m16_opcode;
  logic        m16_first;
  logic        m16_last;
  logic        m16_tvalid;
  logic        m16_tready;
  logic        busy16;
  logic        err16;
  logic [2:0]  err16_code;

  alu_frame_parser #(
    .DataWidth    (16),
    .MaxOperands  (6),
    .TimeoutCycles(100)
  ) u_dut16 (
    .clk_i      (clk),
    .rst_ni     (rst16_n),
    .s_tdata_i  (s16_tdata),
    .s_tvalid_i (s16_tvalid),
    .s_tready_o (s16_tready),
    .m_operand_o(m16_operand),
    .m_opcode_o (m16_opcode),
    .m_first_o  (m16_first),
    .m_last_o   (m16_last),
    .m_tvalid_o (m16_tvalid),
    .m_tready_i (m16_tready),
    .busy_o     (busy16),
    .err_o      (err16),
    .err_code_o (err16_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  op;
    logic        first;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_err_q[$];

  typedef struct {
    logic [7:0] hdr[4];
    int         nwords;
    int         exp_err;
    logic [1:0] op;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input int nw, input int ee,
                              input logic [1:0] op);
    vec_t v;
    v.hdr[0]  = a;
    v.hdr[1]  = b;
    v.hdr[2]  = c;
    v.hdr[3]  = d;
    v.nwords  = nw;
    v.exp_err = ee;
    v.op      = op;
    return v;
  endfunction

  // Monitor: sampled 1 time unit after the falling edge, well clear of the rising edge.
  beat_t    e_beat;
  int       e_err;
  logic     stalled = 1'b0;
  logic [36:0] hold;

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (stalled) begin
        chk("stall_hold", {m_tvalid, m_operand, m_opcode, m_first, m_last}, hold);
      end
      if (m_tvalid && m_tready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {m_operand, m_opcode, m_first, m_last}, 64'd0);
        end else begin
          e_beat = exp_q.pop_front();
          chk("beat_data", m_operand, e_beat.data);
          chk("beat_op", m_opcode, e_beat.op);
          chk("beat_first_last", {m_first, m_last}, {e_beat.first, e_beat.last});
        end
      end else if (m_tvalid) begin
        stalled = 1'b1;
        hold    = {1'b1, m_operand, m_opcode, m_first, m_last};
      end else begin
        stalled = 1'b0;
      end
      if (err) begin
        if (exp_err_q.size() == 0) begin
          chk("unexpected_err", err_code, 64'd0);
        end else begin
          e_err = exp_err_q.pop_front();
          chk("err_code", err_code, e_err);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (!s_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) chk("s_tready_wait", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    s_tvalid = 1'b0;
    while ((exp_q.size() != 0 || exp_err_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size() + exp_err_q.size(), 64'd0);
  endtask

  task automatic send16(input logic [7:0] b);
    int n = 0;
    s16_tdata  = b;
    s16_tvalid = 1'b1;
    while (!s16_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s16_tready) chk("s16_tready_wait", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_word(input int v, input int i);
    return {8'(v + 1), 8'(i * 17 + 3), 8'hA5 ^ 8'(i), 8'h3C + 8'(v)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  vec_t vecs[14];

  initial begin
    int k;
    vecs[0]  = mk(8'hAD, 8'h00, 8'h0C, 8'h00, 2, 0, 2'd0);
    vecs[1]  = mk(8'h63, 8'h00, 8'h10, 8'h00, 3, 0, 2'd1);
    vecs[2]  = mk(8'h5B, 8'h00, 8'h0C, 8'h00, 2, 0, 2'd2);
    vecs[3]  = mk(8'hAD, 8'h00, 8'h1C, 8'h00, 6, 0, 2'd0);
    vecs[4]  = mk(8'h42, 8'h00, 8'h0C, 8'h00, 2, 1, 2'd0);
    vecs[5]  = mk(8'hAD, 8'h01, 8'h0C, 8'h00, 2, 2, 2'd0);
    vecs[6]  = mk(8'hAD, 8'h00, 8'h0D, 8'h00, 2, 3, 2'd0);
    vecs[7]  = mk(8'hAD, 8'h00, 8'h08, 8'h00, 1, 3, 2'd0);
    vecs[8]  = mk(8'hAD, 8'h00, 8'h03, 8'h00, 0, 3, 2'd0);
    vecs[9]  = mk(8'h63, 8'h00, 8'h20, 8'h00, 7, 3, 2'd0);
    vecs[10] = mk(8'h5B, 8'h00, 8'h10, 8'h00, 3, 4, 2'd0);
    vecs[11] = mk(8'h42, 8'h01, 8'h03, 8'h00, 0, 1, 2'd0);
    vecs[12] = mk(8'h5B, 8'h01, 8'h10, 8'h00, 0, 2, 2'd0);
    vecs[13] = mk(8'hAD, 8'h00, 8'h00, 8'h01, 0, 3, 2'd0);

    rst_n      = 1'b0;
    s_tdata    = 8'd0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b1;
    rst16_n    = 1'b0;
    s16_tdata  = 8'd0;
    s16_tvalid = 1'b0;
    m16_tready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_first_last", {m_first, m_last}, 0);
    chk("rst_busy_err", {busy, err}, 0);
    chk("rst_operand", m_operand, 0);
    chk("rst_opcode_code", {m_opcode, err_code}, 0);
    rst_n   = 1'b1;
    rst16_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // Exact-byte add frame
    exp_q.push_back('{32'h1234_5678, 2'd0, 1'b1, 1'b0});
    exp_q.push_back('{32'h0000_0001, 2'd0, 1'b0, 1'b1});
    foreach (vecs[0].hdr[j]) send_byte(vecs[0].hdr[j]);
    send_word(32'h1234_5678);
    send_word(32'h0000_0001);
    drain("add_frame_drain");

    // Same frame with the first beat stalled for 300 clocks
    m_tready = 1'b0;
    exp_q.push_back('{32'h1234_5678, 2'd0, 1'b1, 1'b0});
    exp_q.push_back('{32'h0000_0001, 2'd0, 1'b0, 1'b1});
    foreach (vecs[0].hdr[j]) send_byte(vecs[0].hdr[j]);
    send_word(32'h1234_5678);
    s_tvalid = 1'b0;
    repeat (300) @(negedge clk);
    chk("stall_s_tready", s_tready, 0);
    chk("stall_m_tvalid", m_tvalid, 1);
    chk("stall_busy", busy, 1);
    m_tready = 1'b1;
    send_word(32'h0000_0001);
    drain("stall_frame_drain");

    // Table-driven frames
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].exp_err != 0) exp_err_q.push_back(vecs[v].exp_err);
      else begin
        for (int i = 0; i < vecs[v].nwords; i++) begin
          exp_q.push_back('{gen_word(v, i), vecs[v].op, (i == 0), (i == vecs[v].nwords - 1)});
        end
      end
      for (int j = 0; j < 4; j++) send_byte(vecs[v].hdr[j]);
      for (int i = 0; i < vecs[v].nwords; i++) send_word(gen_word(v, i));
      if (vecs[v].exp_err != 0) begin
        idle(110);
        chk("vec_drop_exit_busy", busy, 0);
      end
      drain("vec_drain");
    end

    // Div count error: pulse one clock after the length byte, then exact 100-clock drop exit
    exp_err_q.push_back(4);
    send_byte(8'h5B);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    chk("div_err_pulse", {err, err_code}, {1'b1, 3'd4});
    for (int i = 0; i < 3; i++) send_word(gen_word(20, i));
    chk("drop_no_valid", m_tvalid, 0);
    idle(99);
    chk("drop_busy_at_99", busy, 1);
    idle(1);
    chk("drop_idle_at_100", busy, 0);
    exp_q.push_back('{32'h1234_5678, 2'd0, 1'b1, 1'b0});
    exp_q.push_back('{32'h0000_0001, 2'd0, 1'b0, 1'b1});
    foreach (vecs[0].hdr[j]) send_byte(vecs[0].hdr[j]);
    send_word(32'h1234_5678);
    send_word(32'h0000_0001);
    drain("after_drop_drain");

    // Mid-frame timeout
    exp_err_q.push_back(5);
    send_byte(8'hAD);
    send_byte(8'h00);
    send_byte(8'h0C);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    s_tvalid = 1'b0;
    k = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (err) begin
        k = i;
        break;
      end
    end
    chk("timeout_latency", k, 100);
    chk("timeout_code", err_code, 5);
    @(negedge clk);
    chk("timeout_busy", busy, 0);
    chk("timeout_pulse_width", err, 0);
    exp_q.push_back('{gen_word(1, 0), 2'd1, 1'b1, 1'b0});
    exp_q.push_back('{gen_word(1, 1), 2'd1, 1'b0, 1'b0});
    exp_q.push_back('{gen_word(1, 2), 2'd1, 1'b0, 1'b1});
    for (int j = 0; j < 4; j++) send_byte(vecs[1].hdr[j]);
    for (int i = 0; i < 3; i++) send_word(gen_word(1, i));
    drain("after_timeout_drain");
    chk("err_code_holds", err_code, 5);

    // 16-bit operands
    send16(8'h63);
    send16(8'h00);
    send16(8'h08);
    send16(8'h00);
    send16(8'h34);
    send16(8'h12);
    chk("w16_beat0", {m16_tvalid, m16_operand, m16_opcode, m16_first, m16_last},
        {1'b1, 16'h1234, 2'd1, 1'b1, 1'b0});
    send16(8'hCD);
    send16(8'hAB);
    chk("w16_beat1", {m16_tvalid, m16_operand, m16_opcode, m16_first, m16_last},
        {1'b1, 16'hABCD, 2'd1, 1'b0, 1'b1});
    s16_tvalid = 1'b0;
    @(negedge clk);
    chk("w16_done", {m16_tvalid, busy16, err16}, 0);

    // Asynchronous reset while a beat is stalled
    m16_tready = 1'b0;
    send16(8'h63);
    send16(8'h00);
    send16(8'h08);
    send16(8'h00);
    send16(8'h34);
    send16(8'h12);
    s16_tvalid = 1'b0;
    chk("w16_pre_rst", {m16_tvalid, busy16, s16_tready}, {1'b1, 1'b1, 1'b0});
    #2;
    rst16_n = 1'b0;
    #1;
    chk("w16_async_rst", {m16_tvalid, busy16, s16_tready, m16_first}, {1'b0, 1'b0, 1'b1, 1'b0});
    chk("w16_rst_regs", {m16_operand, m16_opcode, err16_code}, 0);
    @(negedge clk);
    rst16_n    = 1'b1;
    m16_tready = 1'b1;

    idle(5);
    chk("final_queues", exp_q.size() + exp_err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
